// File: rtl/pwm_audio_out_if.sv
// Sample/control inputs and PWM/status outputs of the stereo PWM audio stage.
// The master drives samples and controls; the slave (pwm_audio_out) drives the pads.
interface pwm_audio_out_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] left_data;
    logic signed [DATA_WIDTH-1:0] right_data;
    logic                         left_valid;
    logic                         right_valid;
    logic [2:0]                   volume;
    logic                         mute;
    logic                         pwm_l;
    logic                         pwm_r;
    logic                         period_start;
    logic [1:0]                   underrun;

    modport master (
        output left_data, right_data, left_valid, right_valid, volume, mute,
        input  pwm_l, pwm_r, period_start, underrun
    );

    modport slave (
        input  left_data, right_data, left_valid, right_valid, volume, mute,
        output pwm_l, pwm_r, period_start, underrun
    );
endinterface

// File: rtl/pwm_audio_out.sv
// Stereo noise-shaped PWM output stage: first-order error feedback, volume shift,
// mute and per-channel underrun watchdog, all in the bclk domain.
module pwm_audio_out #(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned PWM_BITS         = 6,
    parameter int unsigned UNDERRUN_PERIODS = 4
) (
    input  logic           bclk,
    input  logic           rst,
    pwm_audio_out_if.slave audio
);
    localparam int unsigned LSB_BITS = DATA_WIDTH - PWM_BITS;
    localparam int unsigned MISS_W   = $clog2(UNDERRUN_PERIODS + 1);
    localparam logic [MISS_W-1:0]   MISS_MAX = MISS_W'(UNDERRUN_PERIODS);
    localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS - 1){1'b0}}};

    logic [PWM_BITS-1:0] r_cnt;
    logic                r_period_start;
    logic                w_load;
    logic [1:0]          w_valid;
    logic [1:0]          w_pwm;
    logic [1:0]          w_underrun;

    assign w_load  = (r_cnt == {PWM_BITS{1'b1}});
    assign w_valid = {audio.left_valid, audio.right_valid};

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= r_cnt + PWM_BITS'(1);
            r_period_start <= (r_cnt == '0);
        end
    end

    // Channel 1 is left, channel 0 is right, matching the underrun bit order.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] w_data;
        logic signed [DATA_WIDTH-1:0] r_hold;
        logic        [LSB_BITS-1:0]   r_err;
        logic        [PWM_BITS-1:0]   r_duty;
        logic        [MISS_W-1:0]     r_miss;
        logic                         r_seen;
        logic                         r_underrun;
        logic                         r_pwm;
        logic signed [DATA_WIDTH-1:0] w_att;
        logic        [DATA_WIDTH:0]   w_sum;
        logic        [PWM_BITS-1:0]   w_duty_nxt;
        logic        [LSB_BITS-1:0]   w_err_nxt;
        logic        [MISS_W-1:0]     w_miss_inc;

        assign w_data = (ch == 1) ? audio.left_data : audio.right_data;

        always_comb begin
            w_att      = r_hold >>> audio.volume;
            // MSB flip turns the signed sample into an offset-binary level.
            w_sum      = {1'b0, ~w_att[DATA_WIDTH-1], w_att[DATA_WIDTH-2:0]}
                       + {{(PWM_BITS + 1){1'b0}}, r_err};
            w_miss_inc = (r_miss == MISS_MAX) ? r_miss : r_miss + MISS_W'(1);
            w_duty_nxt = w_sum[DATA_WIDTH-1:LSB_BITS];
            w_err_nxt  = w_sum[LSB_BITS-1:0];
            if (audio.mute) begin
                w_duty_nxt = DUTY_MID;
                w_err_nxt  = '0;
            end else if (w_sum[DATA_WIDTH]) begin
                w_duty_nxt = {PWM_BITS{1'b1}};
                w_err_nxt  = '0;
            end
        end

        always_ff @(posedge bclk or posedge rst) begin
            if (rst) begin
                r_hold     <= '0;
                r_err      <= '0;
                r_duty     <= '0;
                r_miss     <= '0;
                r_seen     <= 1'b0;
                r_underrun <= 1'b0;
                r_pwm      <= 1'b0;
            end else begin
                r_pwm <= (r_cnt < r_duty);
                if (w_valid[ch]) begin
                    r_hold     <= w_data;
                    r_underrun <= 1'b0;
                end
                if (w_load) begin
                    r_duty <= w_duty_nxt;
                    r_err  <= w_err_nxt;
                    if (r_seen || w_valid[ch]) begin
                        r_miss <= '0;
                        r_seen <= 1'b0;
                    end else begin
                        r_miss <= w_miss_inc;
                        if (w_miss_inc == MISS_MAX) begin
                            r_underrun <= 1'b1;
                            r_hold     <= '0;
                        end
                    end
                end else if (w_valid[ch]) begin
                    r_seen <= 1'b1;
                end
            end
        end

        assign w_pwm[ch]      = r_pwm;
        assign w_underrun[ch] = r_underrun;
    end

    assign audio.pwm_l        = w_pwm[1];
    assign audio.pwm_r        = w_pwm[0];
    assign audio.period_start = r_period_start;
    assign audio.underrun     = w_underrun;
endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: counts high cycles per PWM period and
// compares duty, underrun and reset behaviour against hand-computed values.
module tb_pwm_audio_out;
    logic bclk = 1'b0;
    logic rst  = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pwm_audio_out_if #(.DATA_WIDTH(16)) aif ();

    pwm_audio_out #(
        .DATA_WIDTH      (16),
        .PWM_BITS        (6),
        .UNDERRUN_PERIODS(4)
    ) dut (
        .bclk (bclk),
        .rst  (rst),
        .audio(aif)
    );

    always #5 bclk = ~bclk;

    task automatic apply_reset();
        rst              = 1'b1;
        aif.left_data    = '0;
        aif.right_data   = '0;
        aif.left_valid   = 1'b0;
        aif.right_valid  = 1'b0;
        aif.volume       = 3'd0;
        aif.mute         = 1'b0;
        repeat (3) @(negedge bclk);
        rst = 1'b0;
    endtask

    // Advance to the next sample with period_start high (first cycle of a period).
    task automatic sync_period();
        int k = 0;
        @(negedge bclk);
        while (aif.period_start !== 1'b1 && k < 200) begin
            @(negedge bclk);
            k++;
        end
        n_tests++;
        if (aif.period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL sync: period_start=%b, required 1 within 200 cycles", aif.period_start);
        end
    endtask

    // Count high cycles over one period starting at the current sample; optional strobes
    // early in the period and a one-cycle mute/volume glitch mid-period.
    task automatic run_period(input bit sl, input bit sr, input bit glitch,
                              output int hl, output int hr);
        logic [2:0] vol_save;
        logic       mute_save;
        vol_save  = aif.volume;
        mute_save = aif.mute;
        hl = 0;
        hr = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge bclk);
            hl += int'(aif.pwm_l);
            hr += int'(aif.pwm_r);
            if (i == 1) begin
                aif.left_valid  = sl;
                aif.right_valid = sr;
            end
            if (i == 2) begin
                aif.left_valid  = 1'b0;
                aif.right_valid = 1'b0;
            end
            if (glitch && i == 10) begin
                aif.mute   = ~mute_save;
                aif.volume = 3'd7;
            end
            if (glitch && i == 11) begin
                aif.mute   = mute_save;
                aif.volume = vol_save;
            end
        end
        @(negedge bclk);
        n_tests++;
        if (aif.period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL period_start alignment: got %b, required 1", aif.period_start);
        end
    endtask

    task automatic test_reset();
        int hl, hr;
        apply_reset();
        rst = 1'b1;
        @(negedge bclk);
        n_tests++;
        if ({aif.pwm_l, aif.pwm_r, aif.period_start, aif.underrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b, required 00000",
                     {aif.pwm_l, aif.pwm_r, aif.period_start, aif.underrun});
        end
        rst = 1'b0;
        sync_period();
        run_period(1'b0, 1'b0, 1'b0, hl, hr);
        n_tests++;
        if (hl != 0 || hr != 0) begin
            n_fail++;
            $display("FAIL reset first period: got l=%0d r=%0d, required l=0 r=0", hl, hr);
        end
        for (int p = 1; p <= 4; p++) begin
            if (p == 3 || p == 4) begin
                n_tests++;
                if (aif.underrun !== ((p == 4) ? 2'b11 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL idle underrun before period %0d: got %b, required %b",
                             p, aif.underrun, (p == 4) ? 2'b11 : 2'b00);
                end
            end
            run_period(1'b0, 1'b0, 1'b0, hl, hr);
            n_tests++;
            if (hl != 32 || hr != 32) begin
                n_fail++;
                $display("FAIL idle duty period %0d: got l=%0d r=%0d, required 32/32", p, hl, hr);
            end
        end
    endtask

    task automatic test_steady();
        int hl, hr;
        apply_reset();
        aif.left_data  = 16'sh4000;
        aif.right_data = 16'shC000;
        sync_period();
        run_period(1'b1, 1'b1, 1'b0, hl, hr);
        for (int p = 1; p <= 3; p++) begin
            run_period(1'b1, 1'b1, 1'b0, hl, hr);
            n_tests++;
            if (hl != 48 || hr != 16) begin
                n_fail++;
                $display("FAIL steady duty period %0d: got l=%0d r=%0d, required 48/16", p, hl, hr);
            end
        end
        n_tests++;
        if (aif.underrun !== 2'b00) begin
            n_fail++;
            $display("FAIL steady underrun: got %b, required 00", aif.underrun);
        end
    endtask

    task automatic test_error_feedback();
        int hl, hr;
        int exp_l[5] = '{32, 32, 32, 33, 32};
        apply_reset();
        aif.left_data  = 16'sh0100;
        aif.right_data = 16'sh0000;
        sync_period();
        run_period(1'b1, 1'b1, 1'b0, hl, hr);
        for (int p = 0; p < 5; p++) begin
            run_period(1'b1, 1'b1, 1'b0, hl, hr);
            n_tests++;
            if (hl != exp_l[p] || hr != 32) begin
                n_fail++;
                $display("FAIL error feedback period %0d: got l=%0d r=%0d, required %0d/32",
                         p + 1, hl, hr, exp_l[p]);
            end
        end
    endtask

    task automatic test_saturation();
        int hl, hr;
        apply_reset();
        aif.left_data  = 16'sh7FFF;
        aif.right_data = 16'sh8000;
        sync_period();
        run_period(1'b1, 1'b1, 1'b0, hl, hr);
        for (int p = 1; p <= 3; p++) begin
            run_period(1'b1, 1'b1, 1'b0, hl, hr);
            n_tests++;
            if (hl != 63 || hr != 0) begin
                n_fail++;
                $display("FAIL saturation period %0d: got l=%0d r=%0d, required 63/0", p, hl, hr);
            end
        end
    endtask

    task automatic test_volume_mute();
        int hl, hr;
        int exp_l[5] = '{36, 36, 32, 32, 36};
        int exp_r[5] = '{28, 28, 32, 32, 28};
        apply_reset();
        aif.volume     = 3'd2;
        aif.left_data  = 16'sh4000;
        aif.right_data = 16'shC000;
        sync_period();
        run_period(1'b1, 1'b1, 1'b0, hl, hr);
        for (int p = 0; p < 5; p++) begin
            if (p == 1) aif.mute = 1'b1;
            if (p == 3) aif.mute = 1'b0;
            run_period(1'b1, 1'b1, (p == 0), hl, hr);
            n_tests++;
            if (hl != exp_l[p] || hr != exp_r[p]) begin
                n_fail++;
                $display("FAIL volume/mute period %0d: got l=%0d r=%0d, required %0d/%0d",
                         p + 1, hl, hr, exp_l[p], exp_r[p]);
            end
        end
    endtask

    task automatic test_underrun_recovery();
        int hl, hr;
        apply_reset();
        aif.left_data  = 16'sh4000;
        aif.right_data = 16'shC000;
        sync_period();
        for (int p = 0; p <= 2; p++) run_period(1'b1, 1'b1, 1'b0, hl, hr);
        n_tests++;
        if (hl != 48) begin
            n_fail++;
            $display("FAIL pre-underrun duty: got %0d, required 48", hl);
        end
        for (int p = 3; p <= 6; p++) begin
            if (p == 6) begin
                n_tests++;
                if (aif.underrun !== 2'b00) begin
                    n_fail++;
                    $display("FAIL underrun after 3 misses: got %b, required 00", aif.underrun);
                end
            end
            run_period(1'b0, 1'b1, 1'b0, hl, hr);
        end
        n_tests++;
        if (aif.underrun !== 2'b10) begin
            n_fail++;
            $display("FAIL underrun after 4 misses: got %b, required 10", aif.underrun);
        end
        run_period(1'b0, 1'b1, 1'b0, hl, hr);
        n_tests++;
        if (hl != 48 || hr != 16) begin
            n_fail++;
            $display("FAIL underrun load-edge duty: got l=%0d r=%0d, required 48/16", hl, hr);
        end
        run_period(1'b1, 1'b1, 1'b0, hl, hr);
        n_tests++;
        if (hl != 32) begin
            n_fail++;
            $display("FAIL underrun silence duty: got %0d, required 32", hl);
        end
        n_tests++;
        if (aif.underrun !== 2'b00) begin
            n_fail++;
            $display("FAIL underrun clear on strobe: got %b, required 00", aif.underrun);
        end
        run_period(1'b1, 1'b1, 1'b0, hl, hr);
        n_tests++;
        if (hl != 48 || hr != 16) begin
            n_fail++;
            $display("FAIL recovered duty: got l=%0d r=%0d, required 48/16", hl, hr);
        end
        // Now at a period start with both outputs high: reset must drop them at once.
        rst = 1'b1;
        #1;
        n_tests++;
        if ({aif.pwm_l, aif.pwm_r, aif.period_start, aif.underrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL async reset outputs: got %b, required 00000",
                     {aif.pwm_l, aif.pwm_r, aif.period_start, aif.underrun});
        end
        @(negedge bclk);
        rst = 1'b0;
        sync_period();
        run_period(1'b0, 1'b0, 1'b0, hl, hr);
        run_period(1'b0, 1'b0, 1'b0, hl, hr);
        n_tests++;
        if (hl != 32 || hr != 32) begin
            n_fail++;
            $display("FAIL post-reset duty: got l=%0d r=%0d, required 32/32", hl, hr);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_error_feedback();
        test_saturation();
        test_volume_mute();
        test_underrun_recovery();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global timeout: simulation still running at 5 ms");
        $fatal(1, "timeout");
    end
endmodule
